par2ser: RTL

PAR2SER -- requirements
Module: par2ser

---
 rtl/par2ser.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/par2ser.sv
// rtl/par2ser.sv - parallel-to-serial shifter with valid/last framing and selectable bit order
// Optional PAR2SER_BUFFER_EN adds a one-word holding register for gapless back-to-back words.
module par2ser #(
  parameter int LENGTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              direct,
  input  logic              ivalid,
  input  logic [LENGTH-1:0] idata,
  output logic              iready,
  output logic              ovalid,
  output logic              odata,
  output logic              olast
);

  localparam int            CW   = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            r_state, w_state_nxt;
  logic [LENGTH-1:0] r_shift, w_shift_nxt;
  logic              r_dir, w_dir_nxt;
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
  logic [CW-1:0]     w_cnt_inc;
  logic              r_ovalid, w_ovalid_nxt;
  logic              r_odata, w_odata_nxt;
  logic              r_olast, w_olast_nxt;

  logic              w_accept;
  logic              w_done;
  logic              w_load;
  logic [LENGTH-1:0] w_ld_data;
  logic              w_ld_dir;

  assign w_done    = (r_state == SHIFT) && (r_cnt == LAST);
  assign w_accept  = enable & ivalid & iready;
  assign w_cnt_inc = r_cnt + 1'b1;

`ifdef PAR2SER_BUFFER_EN
  logic              r_hold_valid, w_hold_valid_nxt;
  logic [LENGTH-1:0] r_hold_data, w_hold_data_nxt;
  logic              r_hold_dir, w_hold_dir_nxt;
  logic              w_load_new;
  logic              w_load_hold;

  assign iready      = enable & reset & ~r_hold_valid;
  assign w_load_hold = enable & w_done & r_hold_valid;
  // A word arriving on the completion edge with the holder empty bypasses it.
  assign w_load_new  = w_accept & ((r_state == IDLE) | w_done);
  assign w_load      = w_load_new | w_load_hold;
  assign w_ld_data   = w_load_hold ? r_hold_data : idata;
  assign w_ld_dir    = w_load_hold ? r_hold_dir : direct;

  always_comb begin
    w_hold_valid_nxt = r_hold_valid;
    w_hold_data_nxt  = r_hold_data;
    w_hold_dir_nxt   = r_hold_dir;
    if (w_load_hold) begin
      w_hold_valid_nxt = 1'b0;
    end
    if (w_accept && !w_load_new) begin
      w_hold_valid_nxt = 1'b1;
      w_hold_data_nxt  = idata;
      w_hold_dir_nxt   = direct;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
      r_hold_dir   <= 1'b0;
    end else begin
      r_hold_valid <= w_hold_valid_nxt;
      r_hold_data  <= w_hold_data_nxt;
      r_hold_dir   <= w_hold_dir_nxt;
    end
  end
`else
  assign iready    = enable & reset & (r_state == IDLE);
  assign w_load    = w_accept;
  assign w_ld_data = idata;
  assign w_ld_dir  = direct;
`endif

  // r_shift holds the bits not yet presented; odata already carries bit r_cnt.
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_dir_nxt    = r_dir;
    w_cnt_nxt    = r_cnt;
    w_ovalid_nxt = r_ovalid;
    w_odata_nxt  = r_odata;
    w_olast_nxt  = r_olast;
    if (enable) begin
      if (w_load) begin
        w_state_nxt  = SHIFT;
        w_dir_nxt    = w_ld_dir;
        w_cnt_nxt    = '0;
        w_ovalid_nxt = 1'b1;
        w_olast_nxt  = 1'b0;
        if (w_ld_dir) begin
          w_odata_nxt = w_ld_data[LENGTH-1];
          w_shift_nxt = {w_ld_data[LENGTH-2:0], 1'b0};
        end else begin
          w_odata_nxt = w_ld_data[0];
          w_shift_nxt = {1'b0, w_ld_data[LENGTH-1:1]};
        end
      end else if (r_state == SHIFT) begin
        if (w_done) begin
          w_state_nxt  = IDLE;
          w_cnt_nxt    = '0;
          w_ovalid_nxt = 1'b0;
          w_odata_nxt  = 1'b0;
          w_olast_nxt  = 1'b0;
        end else begin
          w_cnt_nxt    = w_cnt_inc;
          w_ovalid_nxt = 1'b1;
          w_olast_nxt  = (w_cnt_inc == LAST);
          if (r_dir) begin
            w_odata_nxt = r_shift[LENGTH-1];
            w_shift_nxt = {r_shift[LENGTH-2:0], 1'b0};
          end else begin
            w_odata_nxt = r_shift[0];
            w_shift_nxt = {1'b0, r_shift[LENGTH-1:1]};
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_dir    <= 1'b0;
      r_cnt    <= '0;
      r_ovalid <= 1'b0;
      r_odata  <= 1'b0;
      r_olast  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_dir    <= w_dir_nxt;
      r_cnt    <= w_cnt_nxt;
      r_ovalid <= w_ovalid_nxt;
      r_odata  <= w_odata_nxt;
      r_olast  <= w_olast_nxt;
    end
  end

  assign ovalid = r_ovalid;
  assign odata  = r_odata;
  assign olast  = r_olast;

endmodule
